load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_if.sv | 20 ++
 rtl/lsu_align.sv | 81 ++++++++
 rtl/load_store_unit.sv | 116 +++++++++++
 tb/tb_load_store_unit.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3 codes,
// byte-enable patterns and the illegal-encoding check.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam logic [3:0] BE_BYTE0 = 4'b0001;
    localparam logic [3:0] BE_LO    = 4'b0011;
    localparam logic [3:0] BE_HI    = 4'b1100;
    localparam logic [3:0] BE_ALL   = 4'b1111;

    // Unsigned variants exist only for loads.
    function automatic logic lsu_illegal(input logic [2:0] f3, input logic store);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (store && f3[2]);
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Word-wide memory-side bus of the load/store unit; the LSU is the master.
interface lsu_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication, load extension.
// MISALIGN_TRAP_EN: flag misaligned half/word accesses instead of aligning them.
import lsu_pkg::*;

module lsu_align (
    input  logic [2:0]  st_f3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic        is_store,
    input  logic [2:0]  ld_f3,
    input  logic [1:0]  ld_lane,
    input  logic [31:0] rdata,
    output logic [1:0]  lane,
    output logic        trap,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Low address bits are forced to the natural alignment of the access size.
    always_comb begin
        lane = 2'b00;
        case (st_f3[1:0])
            2'b00:   lane = addr_lo;
            2'b01:   lane = {addr_lo[1], 1'b0};
            default: lane = 2'b00;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    assign trap = ((st_f3[1:0] == 2'b01) && addr_lo[0]) ||
                  ((st_f3[1:0] == 2'b10) && (addr_lo != 2'b00));
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        be    = BE_ALL;
        wdata = st_data;
        if (is_store) begin
            case (st_f3)
                SB: begin
                    be    = BE_BYTE0 << lane;
                    wdata = {4{st_data[7:0]}};
                end
                SH: begin
                    be    = lane[1] ? BE_HI : BE_LO;
                    wdata = {2{st_data[15:0]}};
                end
                default: begin
                    be    = BE_ALL;
                    wdata = st_data;
                end
            endcase
        end
    end

    always_comb begin
        ld_byte = rdata[7:0];
        case (ld_lane)
            2'd0:    ld_byte = rdata[7:0];
            2'd1:    ld_byte = rdata[15:8];
            2'd2:    ld_byte = rdata[23:16];
            default: ld_byte = rdata[31:24];
        endcase
        ld_half = ld_lane[1] ? rdata[31:16] : rdata[15:0];

        ld_data = rdata;
        case (ld_f3)
            LB:      ld_data = {{24{ld_byte[7]}}, ld_byte};
            LH:      ld_data = {{16{ld_half[15]}}, ld_half};
            LBU:     ld_data = {24'd0, ld_byte};
            LHU:     ld_data = {16'd0, ld_half};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: IDLE/REQ/DONE sequencer with a saturating timeout counter.
// MISALIGN_TRAP_EN (in lsu_align) turns misaligned accesses into faults.
import lsu_pkg::*;

module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] aluOut,
    input  logic [31:0] readData2,
    input  logic [2:0]  funct3,
    output logic [31:0] readDataDMem,
    output logic        stall,
    output logic        fault,
    lsu_mem_if.master   mem
);

    //  state | meaning
    //  IDLE  | waiting for memread/memwrite; latch access or reject it
    //  REQ   | mem_req high, bus held stable until mem_ready or timeout
    //  DONE  | one cycle, stall low so the core advances; fault pulses here

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);

    lsu_state_t    state;
    logic [CW-1:0] cnt;
    logic [2:0]    f3_q;
    logic [1:0]    lane_q;

    logic [1:0]    lane;
    logic          trap;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   ld_data;
    logic          reject;

    lsu_align u_align (
        .st_f3   (funct3),
        .addr_lo (aluOut[1:0]),
        .st_data (readData2),
        .is_store(memwrite),
        .ld_f3   (f3_q),
        .ld_lane (lane_q),
        .rdata   (mem.mem_rdata),
        .lane    (lane),
        .trap    (trap),
        .be      (be),
        .wdata   (wdata),
        .ld_data (ld_data)
    );

    assign reject = lsu_illegal(funct3, memwrite) | trap;
    assign stall  = (memread | memwrite) & (state != DONE);

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state         <= IDLE;
            cnt           <= '0;
            f3_q          <= '0;
            lane_q        <= '0;
            fault         <= 1'b0;
            readDataDMem  <= '0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_be    <= '0;
            mem.mem_wdata <= '0;
        end else begin
            fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (memread | memwrite) begin
                        cnt <= '0;
                        if (reject) begin
                            state <= DONE;
                            fault <= 1'b1;
                        end else begin
                            state         <= REQ;
                            f3_q          <= funct3;
                            lane_q        <= lane;
                            mem.mem_req   <= 1'b1;
                            mem.mem_we    <= memwrite;
                            mem.mem_addr  <= {aluOut[31:2], 2'b00};
                            mem.mem_be    <= be;
                            mem.mem_wdata <= wdata;
                        end
                    end
                end
                REQ: begin
                    if (cnt != CNT_MAX)
                        cnt <= cnt + CW'(1);
                    if (mem.mem_ready) begin
                        state       <= DONE;
                        mem.mem_req <= 1'b0;
                        if (!mem.mem_we)
                            readDataDMem <= ld_data;
                    end else if (cnt == CNT_LAST) begin
                        state       <= DONE;
                        mem.mem_req <= 1'b0;
                        fault       <= 1'b1;
                        if (!mem.mem_we)
                            readDataDMem <= '0;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table plus timeout and reset sequences.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clock = 1'b0;
    logic        reset_;
    logic        memread, memwrite;
    logic [31:0] aluOut, readData2;
    logic [2:0]  funct3;
    logic [31:0] readDataDMem;
    logic        stall, fault;

    lsu_mem_if mem();

    load_store_unit #(.TIMEOUT_CYCLES(255)) dut (
        .clock       (clock),
        .reset_      (reset_),
        .memread     (memread),
        .memwrite    (memwrite),
        .aluOut      (aluOut),
        .readData2   (readData2),
        .funct3      (funct3),
        .readDataDMem(readDataDMem),
        .stall       (stall),
        .fault       (fault),
        .mem         (mem)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        logic        exp_fault;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdd;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs[NV];
    logic [31:0] model_rdd;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{0, 1, SW,     32'h100, 32'hDEADBEEF, 32'h0,        0, 0, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1, 0, LB,     32'h103, 32'h0,        32'h80FFFF7F, 0, 0, 32'h100, 4'b1111, 32'h0,        32'hFFFFFF80};
        vecs[2]  = '{1, 0, LBU,    32'h103, 32'h0,        32'h80FFFF7F, 1, 0, 32'h100, 4'b1111, 32'h0,        32'h00000080};
        vecs[3]  = '{0, 1, SH,     32'h202, 32'h1234ABCD, 32'h0,        0, 0, 32'h200, 4'b1100, 32'hABCDABCD, 32'h0};
        vecs[4]  = '{0, 1, SB,     32'h301, 32'h000000A5, 32'h0,        2, 0, 32'h300, 4'b0010, 32'hA5A5A5A5, 32'h0};
        vecs[5]  = '{1, 0, LH,     32'h012, 32'h0,        32'h80017FFE, 0, 0, 32'h010, 4'b1111, 32'h0,        32'hFFFF8001};
        vecs[6]  = '{1, 0, LHU,    32'h010, 32'h0,        32'h8001F00D, 0, 0, 32'h010, 4'b1111, 32'h0,        32'h0000F00D};
        vecs[7]  = '{1, 0, LW,     32'h020, 32'h0,        32'hCAFEF00D, 3, 0, 32'h020, 4'b1111, 32'h0,        32'hCAFEF00D};
        vecs[8]  = '{1, 0, LB,     32'h101, 32'h0,        32'h123456F0, 0, 0, 32'h100, 4'b1111, 32'h0,        32'h00000056};
        vecs[9]  = '{1, 0, 3'b011, 32'h040, 32'h0,        32'hFFFFFFFF, 0, 1, 32'h0,   4'b0000, 32'h0,        32'h0};
        vecs[10] = '{0, 1, 3'b100, 32'h044, 32'h11111111, 32'h0,        0, 1, 32'h0,   4'b0000, 32'h0,        32'h0};
        vecs[11] = '{1, 0, 3'b110, 32'h048, 32'h0,        32'hFFFFFFFF, 0, 1, 32'h0,   4'b0000, 32'h0,        32'h0};
        vecs[12] = '{1, 1, SW,     32'h050, 32'h11223344, 32'hFFFFFFFF, 0, 0, 32'h050, 4'b1111, 32'h11223344, 32'h0};
`ifdef MISALIGN_TRAP_EN
        vecs[13] = '{1, 0, LW,     32'h041, 32'h0,        32'h5555AAAA, 0, 1, 32'h0,   4'b0000, 32'h0,        32'h0};
        vecs[14] = '{0, 1, SH,     32'h203, 32'h0000BEEF, 32'h0,        0, 1, 32'h0,   4'b0000, 32'h0,        32'h0};
`else
        vecs[13] = '{1, 0, LW,     32'h041, 32'h0,        32'h5555AAAA, 0, 0, 32'h040, 4'b1111, 32'h0,        32'h5555AAAA};
        vecs[14] = '{0, 1, SH,     32'h203, 32'h0000BEEF, 32'h0,        0, 0, 32'h200, 4'b1100, 32'hBEEFBEEF, 32'h0};
`endif
        vecs[15] = '{0, 1, SB,     32'h302, 32'h00000077, 32'h0,        0, 0, 32'h300, 4'b0100, 32'h77777777, 32'h0};

        reset_ = 1'b0;
        memread = 1'b0; memwrite = 1'b0;
        aluOut = '0; readData2 = '0; funct3 = '0;
        mem.mem_ready = 1'b0; mem.mem_rdata = '0;
        model_rdd = '0;
        #1;
        check("reset mem_req",   mem.mem_req,   0);
        check("reset mem_we",    mem.mem_we,    0);
        check("reset mem_addr",  mem.mem_addr,  0);
        check("reset mem_be",    mem.mem_be,    0);
        check("reset mem_wdata", mem.mem_wdata, 0);
        check("reset rdd",       readDataDMem,  0);
        check("reset fault",     fault,         0);
        repeat (2) @(negedge clock);
        reset_ = 1'b1;

        for (int i = 0; i < NV; i++) begin
            int cyc;
            int nreq;
            bit bus_ok;
            bit done;
            cyc = 0; nreq = 0; bus_ok = 1'b1; done = 1'b0;
            @(negedge clock);
            memread = vecs[i].rd; memwrite = vecs[i].wr; funct3 = vecs[i].f3;
            aluOut = vecs[i].addr; readData2 = vecs[i].wdata;
            mem.mem_rdata = vecs[i].rdata; mem.mem_ready = 1'b0;
            while (!done && cyc < 20) begin
                @(posedge clock); #1;
                cyc++;
                if (mem.mem_req) begin
                    if (mem.mem_addr !== vecs[i].exp_addr || mem.mem_be !== vecs[i].exp_be ||
                        mem.mem_we !== vecs[i].wr ||
                        (vecs[i].wr && mem.mem_wdata !== vecs[i].exp_wdata))
                        bus_ok = 1'b0;
                    mem.mem_ready = (nreq == vecs[i].delay);
                    nreq++;
                end else begin
                    mem.mem_ready = 1'b0;
                end
                if (!stall) done = 1'b1;
            end
            check($sformatf("v%0d stall cycles", i), cyc, vecs[i].exp_fault ? 1 : 2 + vecs[i].delay);
            check($sformatf("v%0d fault", i), fault, vecs[i].exp_fault);
            check($sformatf("v%0d req cycles", i), nreq, vecs[i].exp_fault ? 0 : vecs[i].delay + 1);
            check($sformatf("v%0d bus fields", i), bus_ok, 1);
            if (vecs[i].rd && !vecs[i].wr && !vecs[i].exp_fault)
                model_rdd = vecs[i].exp_rdd;
            check($sformatf("v%0d readDataDMem", i), readDataDMem, model_rdd);
            @(negedge clock);
            memread = 1'b0; memwrite = 1'b0;
            @(posedge clock); #1;
            check($sformatf("v%0d fault cleared", i), fault, 0);
            check($sformatf("v%0d mem_req idle", i), mem.mem_req, 0);
        end

        // Timeout: memory never answers.
        begin
            int nreq;
            int nfault;
            nreq = 0; nfault = 0;
            @(negedge clock);
            memread = 1'b1; memwrite = 1'b0; funct3 = LW; aluOut = 32'h40;
            mem.mem_ready = 1'b0; mem.mem_rdata = 32'h12345678;
            for (int c = 0; c < 300; c++) begin
                @(posedge clock); #1;
                if (mem.mem_req) nreq++;
                if (fault) nfault++;
                if (!stall && memread) memread = 1'b0;
            end
            check("timeout req cycles",  nreq,         255);
            check("timeout fault count", nfault,       1);
            check("timeout rdd zero",    readDataDMem, 0);

            // mem_ready outside REQ must have no effect.
            nreq = 0; nfault = 0;
            mem.mem_ready = 1'b1; mem.mem_rdata = 32'hFFFFFFFF;
            repeat (5) begin
                @(posedge clock); #1;
                if (mem.mem_req) nreq++;
                if (fault) nfault++;
            end
            check("idle ready req",   nreq,         0);
            check("idle ready fault", nfault,       0);
            check("idle ready rdd",   readDataDMem, 0);
            mem.mem_ready = 1'b0;
        end

        // Reset asserted while a request is outstanding.
        begin
            int nreq;
            int nfault;
            nreq = 0; nfault = 0;
            @(negedge clock);
            memread = 1'b1; funct3 = LW; aluOut = 32'h60;
            repeat (3) @(posedge clock);
            #3;
            check("pre-reset mem_req", mem.mem_req, 1);
            reset_ = 1'b0;
            #1;
            check("async reset mem_req", mem.mem_req, 0);
            check("async reset state", 32'(dut.state), 32'(IDLE));
            @(negedge clock);
            memread = 1'b0;
            @(negedge clock);
            reset_ = 1'b1;
            mem.mem_ready = 1'b1;
            repeat (5) begin
                @(posedge clock); #1;
                if (mem.mem_req) nreq++;
                if (fault) nfault++;
            end
            check("post-reset req",   nreq,   0);
            check("post-reset fault", nfault, 0);
            mem.mem_ready = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
